// File: rtl/rr_arbiter4_pkg.sv
// Shared types and the round-robin pick helper
// for the 4-way arbiter.
package arb_pkg;

  localparam int NREQ  = 4;
  localparam int IDX_W = 2;

  typedef enum logic {
    ARB_IDLE,
    ARB_BUSY
  } arb_state_e;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } pick_t;

  // Descending scan so the lowest offset from ptr is written last and wins
  function automatic pick_t rr_pick(
    input logic [NREQ-1:0]  req,
    input logic [IDX_W-1:0] ptr
  );
    pick_t            p;
    logic [IDX_W-1:0] j;
    p = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = ptr + IDX_W'(k);
      if (req[j]) begin
        p.found = 1'b1;
        p.idx   = j;
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/rr_arbiter4_if.sv
// Request/grant bundle between the requesters
// (master) and the arbiter (slave).
interface rr_arbiter4_if;
  import arb_pkg::*;

  logic [NREQ-1:0]  req;
  logic [NREQ-1:0]  grant;
  logic [IDX_W-1:0] grant_idx;
  logic             grant_vld;
  logic             timeout;

  modport master (
    output req,
    input  grant,
    input  grant_idx,
    input  grant_vld,
    input  timeout
  );

  modport slave (
    input  req,
    output grant,
    output grant_idx,
    output grant_vld,
    output timeout
  );

endinterface

// File: rtl/rr_arbiter4_decoder2to4.sv
// 2-to-4 one-hot decoder used to expand
// the registered winner index.
module decoder2to4 (
  input  logic [1:0] i,
  output logic       y0,
  output logic       y1,
  output logic       y2,
  output logic       y3
);

  always_comb begin
    {y3, y2, y1, y0} = 4'b0000;
    unique case (1'b1)
      (i == 2'd0): y0 = 1'b1;
      (i == 2'd1): y1 = 1'b1;
      (i == 2'd2): y2 = 1'b1;
      (i == 2'd3): y3 = 1'b1;
      default:     y0 = 1'b0;
    endcase
  end

endmodule

// File: rtl/rr_arbiter4.sv
// 4-way round-robin arbiter with grant lock.
// Define ARB_TIMEOUT_EN to force release after MAX_HOLD cycles.
module rr_arbiter4
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  rr_arbiter4_if.slave  bus
);

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] ptr_nx;
  logic [NREQ-1:0]  req_m;
  pick_t            pick;
  logic             hold_req;
  logic             force_rel;
  logic             y0, y1, y2, y3;

  assign hold_req = bus.req[idx_q];
  assign ptr_nx   = idx_q + IDX_W'(1);

`ifdef ARB_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             to_q;

  assign force_rel = (state_q == ARB_BUSY) && hold_req &&
                     (cnt_q == CNT_W'(MAX_HOLD - 1));

  // Counter restarts on any grant change, including a forced re-grant
  always_comb begin
    cnt_d = '0;
    if (state_q == ARB_BUSY && state_d == ARB_BUSY &&
        idx_d == idx_q && !force_rel)
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      to_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      to_q  <= force_rel;
    end
  end

  assign bus.timeout = to_q;
`else
  logic unused_cfg;

  assign unused_cfg  = ^{CNT_W'(MAX_HOLD)};
  assign force_rel   = 1'b0;
  assign bus.timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    req_m   = bus.req;
    pick    = rr_pick(bus.req, ptr_q);
    unique case (state_q)
      ARB_IDLE: begin
        if (pick.found) begin
          state_d = ARB_BUSY;
          idx_d   = pick.idx;
        end
      end
      ARB_BUSY: begin
        if (!hold_req || force_rel) begin
          ptr_d        = ptr_nx;
          req_m[idx_q] = 1'b0;
          pick         = rr_pick(req_m, ptr_nx);
          if (pick.found)
            idx_d = pick.idx;
          else if (!force_rel)
            state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB_IDLE;
      idx_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
    end
  end

  decoder2to4 u_dec (
    .i  (idx_q),
    .y0 (y0),
    .y1 (y1),
    .y2 (y2),
    .y3 (y3)
  );

  assign bus.grant_vld = (state_q == ARB_BUSY);
  assign bus.grant_idx = idx_q;
  assign bus.grant     = {y3, y2, y1, y0} &
                         {NREQ{bus.grant_vld}};

endmodule

// File: tb/tb_rr_arbiter4.sv
// Table-driven bench for rr_arbiter4 with an
// expected-result queue per driven cycle.
module tb_rr_arbiter4;

  typedef struct {
    logic [3:0] req;
    logic [3:0] grant;
    logic       to;
  } vec_t;

  typedef struct {
    logic [3:0] grant;
    logic       to;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;
  vec_t tbl [19];
  exp_t sb [$];

  rr_arbiter4_if bus ();

  rr_arbiter4 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] oh2i(input logic [3:0] g);
    logic [1:0] r;
    r = 2'd0;
    if (g[1]) r = 2'd1;
    if (g[2]) r = 2'd2;
    if (g[3]) r = 2'd3;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [7:0] act,
                     input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic chk_out(input string nm, input logic [3:0] g,
                         input logic to);
    chk({nm, " grant"}, 8'(bus.grant), 8'(g));
    chk({nm, " vld"}, 8'(bus.grant_vld), 8'(|g));
    chk({nm, " timeout"}, 8'(bus.timeout), 8'(to));
    if (|g)
      chk({nm, " idx"}, 8'(bus.grant_idx), 8'(oh2i(g)));
  endtask

  task automatic step(input string nm, input logic [3:0] r,
                      input logic [3:0] g, input logic to);
    exp_t e;
    @(negedge clk);
    bus.req = r;
    sb.push_back('{grant: g, to: to});
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk({nm, " sb_empty"}, 8'd1, 8'd0);
    end else begin
      e = sb.pop_front();
      chk_out(nm, e.grant, e.to);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{4'b1110, 4'b0010, 1'b0};
    tbl[1]  = '{4'b1101, 4'b0100, 1'b0};
    tbl[2]  = '{4'b1011, 4'b1000, 1'b0};
    tbl[3]  = '{4'b0111, 4'b0001, 1'b0};
    tbl[4]  = '{4'b0111, 4'b0001, 1'b0};
    tbl[5]  = '{4'b0110, 4'b0010, 1'b0};
    tbl[6]  = '{4'b0100, 4'b0100, 1'b0};
    tbl[7]  = '{4'b1000, 4'b1000, 1'b0};
    tbl[8]  = '{4'b0000, 4'b0000, 1'b0};
    tbl[9]  = '{4'b0011, 4'b0001, 1'b0};
    tbl[10] = '{4'b1010, 4'b0010, 1'b0};
    tbl[11] = '{4'b1100, 4'b0100, 1'b0};
    tbl[12] = '{4'b0001, 4'b0001, 1'b0};
    tbl[13] = '{4'b0101, 4'b0001, 1'b0};
    tbl[14] = '{4'b0001, 4'b0001, 1'b0};
    tbl[15] = '{4'b0000, 4'b0000, 1'b0};
    tbl[16] = '{4'b0101, 4'b0100, 1'b0};
    tbl[17] = '{4'b0000, 4'b0000, 1'b0};
    tbl[18] = '{4'b0011, 4'b0001, 1'b0};

    rst_n   = 1'b0;
    bus.req = 4'b1111;
    #12;
    chk_out("reset", 4'b0000, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk_out("rel_pre", 4'b0000, 1'b0);
    @(posedge clk);
    #1;
    chk_out("rel_first", 4'b0001, 1'b0);

    for (int n = 0; n < 19; n++)
      step($sformatf("vec%0d", n), tbl[n].req,
           tbl[n].grant, tbl[n].to);

    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk_out("mid_rst", 4'b0000, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk_out("mid_rel_pre", 4'b0000, 1'b0);
    @(posedge clk);
    #1;
    chk_out("mid_rel", 4'b0001, 1'b0);

`ifdef ARB_TIMEOUT_EN
    for (int n = 0; n < 15; n++)
      step($sformatf("hold0_%0d", n), 4'b0011, 4'b0001, 1'b0);
    step("to_switch", 4'b0011, 4'b0010, 1'b1);
    for (int n = 0; n < 15; n++)
      step($sformatf("hold1_%0d", n), 4'b0010, 4'b0010, 1'b0);
    step("to_regrant", 4'b0010, 4'b0010, 1'b1);
    step("after_regrant", 4'b0010, 4'b0010, 1'b0);
`else
    for (int n = 0; n < 20; n++)
      step($sformatf("lock%0d", n), 4'b0101, 4'b0001, 1'b0);
    step("lock_rel", 4'b0100, 4'b0100, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
